gate_sweeper: RTL and testbench



---
 rtl/gate_pkg.sv | 12 +
 rtl/gate_reduce.sv | 24 ++
 rtl/gate_sweeper.sv | 51 +++++
 tb/tb_gate_sweeper.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// gate_pkg: gate function codes and sweep FSM state encoding
package gate_pkg;
  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_XOR  = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;
  localparam logic [2:0] GATE_BUF  = 3'd6;
  localparam logic [2:0] GATE_NOT  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_DONE} state_t;
endpackage

// File: rtl/gate_reduce.sv
// gate_reduce: selectable reduction gate over all N_IN inputs
module gate_reduce
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      mode,
  input  logic [N_IN-1:0] in,
  output logic            y
);
  always_comb begin
    y = 1'b0;
    case (mode)
      GATE_AND:  y = &in;
      GATE_OR:   y = |in;
      GATE_XOR:  y = ^in;
      GATE_NAND: y = ~&in;
      GATE_NOR:  y = ~|in;
      GATE_XNOR: y = ~^in;
      GATE_BUF:  y = in[0];
      default:   y = ~in[0];
    endcase
  end
endmodule

// File: rtl/gate_sweeper.sv
// gate_sweeper: sweeps every input vector through gate_reduce and records the truth table
module gate_sweeper
  import gate_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mode,
  output logic                 busy,
  output logic                 done,
  output logic [N_IN-1:0]      vec_out,
  output logic                 y_out,
  output logic                 sample,
  output logic [2**N_IN-1:0]   table_out
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  state_t state, state_nx;
  logic [2:0] mode_q;
  logic [HW-1:0] hold;
  gate_reduce #(.N_IN(N_IN)) u_gate (.mode(mode_q), .in(vec_out), .y(y_out));
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nx;
  always_comb begin
    busy     = state == ST_APPLY;
    done     = state == ST_DONE;
    sample   = busy && hold == HOLD_LAST;
    state_nx = state == ST_IDLE  ? (start ? ST_APPLY : ST_IDLE) :
               state == ST_APPLY ? (sample && &vec_out ? ST_DONE : ST_APPLY) : ST_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      mode_q    <= '0;
      hold      <= '0;
      vec_out   <= '0;
      table_out <= '0;
    end else if (state == ST_IDLE && start) begin
      mode_q    <= mode;
      hold      <= '0;
      vec_out   <= '0;
      table_out <= '0;
    end else if (busy) begin
      hold <= sample ? '0 : hold + 1'b1;
      if (sample) begin
        vec_out            <= vec_out + 1'b1;
        table_out[vec_out] <= y_out;
      end
    end
endmodule

// File: tb/tb_gate_sweeper.sv
// tb_gate_sweeper: table-driven and randomized sweeps over three gate_sweeper configurations
module tb_gate_sweeper;
  import gate_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = '0;
  logic [2:0] mode = '0;
  logic [2:0] b, dn, y, sp;
  logic [1:0] v0, v2;
  logic [2:0] v1;
  logic [3:0] t0, t2;
  logic [7:0] t1;
  int sel = 0;
  logic [7:0] c_tbl;
  logic [2:0] c_vec;
  logic c_busy, c_done, c_sample, c_y;
  int n_cmp = 0, n_bad = 0;
  int n_of[3] = '{2, 3, 2};
  int h_of[3] = '{1, 1, 3};
  always #5 clk = ~clk;
  gate_sweeper #(.N_IN(2), .HOLD_CYC(1)) d0 (.clk(clk), .rst(rst), .start(st[0]), .mode(mode), .busy(b[0]),
    .done(dn[0]), .vec_out(v0), .y_out(y[0]), .sample(sp[0]), .table_out(t0));
  gate_sweeper #(.N_IN(3), .HOLD_CYC(1)) d1 (.clk(clk), .rst(rst), .start(st[1]), .mode(mode), .busy(b[1]),
    .done(dn[1]), .vec_out(v1), .y_out(y[1]), .sample(sp[1]), .table_out(t1));
  gate_sweeper #(.N_IN(2), .HOLD_CYC(3)) d2 (.clk(clk), .rst(rst), .start(st[2]), .mode(mode), .busy(b[2]),
    .done(dn[2]), .vec_out(v2), .y_out(y[2]), .sample(sp[2]), .table_out(t2));
  always_comb begin
    c_tbl    = sel == 0 ? {4'b0, t0} : sel == 1 ? t1 : {4'b0, t2};
    c_vec    = sel == 0 ? {1'b0, v0} : sel == 1 ? v1 : {1'b0, v2};
    c_busy   = b[sel];
    c_done   = dn[sel];
    c_sample = sp[sel];
    c_y      = y[sel];
  end
  function automatic bit ref_y(input logic [2:0] m, input int n, input int v);
    int ones = $countones(v);
    case (m)
      3'd0: ref_y = ones == n;
      3'd1: ref_y = ones > 0;
      3'd2: ref_y = ones % 2 == 1;
      3'd3: ref_y = ones != n;
      3'd4: ref_y = ones == 0;
      3'd5: ref_y = ones % 2 == 0;
      3'd6: ref_y = v % 2 == 1;
      default: ref_y = v % 2 == 0;
    endcase
  endfunction
  function automatic logic [7:0] ref_tbl(input logic [2:0] m, input int n);
    ref_tbl = '0;
    for (int i = 0; i < (1 << n); i++) ref_tbl[i] = ref_y(m, n, i);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s (inst %0d): got %0h expected %0h at %0t", nm, sel, a, e, $time);
    end
  endtask
  task automatic sweep(input int s, input logic [2:0] m, input bit noise, input logic [7:0] exp);
    int n = n_of[s];
    int h = h_of[s];
    int len = (1 << n) * h;
    int smp = 0;
    sel = s;
    @(negedge clk);
    chk("idle_before_start", {30'd0, c_busy, c_done}, 0);
    st = '0;
    st[s] = 1'b1;
    mode = m;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      st[s] = noise && k > 1;
      if (noise) mode = 3'($urandom);
      if (k == 1) chk("tbl_clear", c_tbl, 0);
      if (k <= len) begin
        chk("busy", c_busy, 1);
        chk("done_early", c_done, 0);
        chk("vec", c_vec, (k - 1) / h);
        chk("sample", c_sample, (k - 1) % h == h - 1);
        chk("y", c_y, ref_y(m, n, (k - 1) / h));
        smp += c_sample;
      end else begin
        chk("done", c_done, 1);
        chk("busy_in_done", c_busy, 0);
        chk("vec_wrap", c_vec, 0);
        chk("table", c_tbl, exp);
        chk("sample_count", smp, 1 << n);
      end
    end
  endtask
  typedef struct { int s; logic [2:0] m; logic [7:0] tbl; } vec_t;
  vec_t tv[8];
  initial begin
    logic [2:0] rm;
    int rs;
    bit seen;
    tv[0] = '{0, GATE_AND,  8'h08};
    tv[1] = '{1, GATE_XOR,  8'h96};
    tv[2] = '{1, GATE_XNOR, 8'h69};
    tv[3] = '{0, GATE_NOR,  8'h01};
    tv[4] = '{0, GATE_BUF,  8'h0A};
    tv[5] = '{0, GATE_NOT,  8'h05};
    tv[6] = '{2, GATE_AND,  8'h08};
    tv[7] = '{2, GATE_OR,   8'h0E};
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_state", {c_busy, c_done, c_sample, c_vec, c_tbl}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) sweep(tv[i].s, tv[i].m, 1'b0, tv[i].tbl);
    sweep(0, GATE_XOR, 1'b1, 8'h06);
    sweep(0, GATE_NAND, 1'b0, 8'h07);
    sweep(2, GATE_NOR, 1'b1, 8'h01);
    sweep(2, GATE_XNOR, 1'b0, 8'h09);
    for (int r = 0; r < 12; r++) begin
      rs = $urandom_range(0, 2);
      rm = 3'($urandom);
      sweep(rs, rm, 1'($urandom), ref_tbl(rm, n_of[rs]));
    end
    sel = 0;
    @(negedge clk);
    st = '0;
    st[0] = 1'b1;
    mode = GATE_OR;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_table", c_tbl, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {c_busy, c_done, c_sample, c_vec, c_tbl}, 0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= c_done | c_busy;
    end
    chk("no_done_after_rst", seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
